// File: rtl/ci_symbol_interleaver_pkg.sv
// Shared types and elaboration-time helpers for the CI symbol interleaver.
// Branch lengths are computed here so the top and the bench agree on geometry.
package ci_pkg;

   typedef enum logic {
      CI_INTERLEAVE   = 1'b0,
      CI_DEINTERLEAVE = 1'b1
   } ci_mode_e;

   // Interleave gives branch 0 the longest delay; deinterleave mirrors it.
   function automatic int branch_len(ci_mode_e mode, int i, int p, int d);
      return (mode == CI_INTERLEAVE) ? (p - 1 - i) * d : i * d;
   endfunction

   function automatic int clog2_min1(int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ci_symbol_interleaver_branch.sv
// One interleaver branch: a circular buffer of LEN symbols with fill tracking.
// Output reads as zero until the buffer has been written LEN times since reset.
module ci_branch_buf
   import ci_pkg::*;
#(
   parameter int SW  = 10,
   parameter int LEN = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [SW-1:0] wr_data,
   output logic [SW-1:0] rd_data,
   output logic          full
);

   generate
      if (LEN == 0) begin : g_bypass
         logic bypass_unused;
         assign bypass_unused = ^{clk, rst};
         assign rd_data       = wr_data;
         assign full          = 1'b1;
      end else begin : g_buf
         localparam int PW = clog2_min1(LEN);
         localparam int CW = clog2_min1(LEN + 1);
         localparam logic [PW-1:0] PTR_LAST = PW'(LEN - 1);
         localparam logic [CW-1:0] CNT_FULL = CW'(LEN);

         logic [SW-1:0] mem [LEN];
         logic [PW-1:0] ptr;
         logic [CW-1:0] cnt;

         // Storage is deliberately not reset; the fill counter masks stale data.
         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem[ptr] <= wr_data;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               ptr <= '0;
               cnt <= '0;
            end else if (wr_en) begin
               ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
               if (cnt != CNT_FULL) begin
                  cnt <= cnt + 1'b1;
               end
            end
         end

         assign full    = (cnt == CNT_FULL);
         assign rd_data = full ? mem[ptr] : '0;
      end
   endgenerate

endmodule

// File: rtl/ci_symbol_interleaver.sv
// Symbol-wide convolutional interleaver/deinterleaver with valid/ready on both sides.
// A commutator spreads symbols over P circular-buffer branches into one output register.
module ci_symbol_interleaver
   import ci_pkg::*;
#(
   parameter int M    = 10,
   parameter int W    = 1,
   parameter int D    = 2,
   parameter int P    = 4,
   parameter int MODE = 0,
   localparam int SW  = M * W,
   localparam int BW  = clog2_min1(P)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [SW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sync,
   output logic [SW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [BW-1:0] out_branch,
   output logic          out_primed
);

   localparam ci_mode_e MODE_E = (MODE == 0) ? CI_INTERLEAVE : CI_DEINTERLEAVE;

   logic [BW-1:0] idx;
   logic [BW-1:0] branch_sel;
   logic [BW-1:0] idx_next;
   logic          accept;
   logic [SW-1:0] rd_data [P];
   logic [P-1:0]  full;
   logic [P-1:0]  wr_en;
   logic [P-1:0]  emitted;
   logic [P-1:0]  emitted_next;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      branch_sel = in_sync ? '0 : idx;
      idx_next   = (int'(branch_sel) == P - 1) ? '0 : branch_sel + 1'b1;
   end

   generate
      for (genvar b = 0; b < P; b++) begin : g_branch
         assign wr_en[b] = accept && (int'(branch_sel) == b);

         ci_branch_buf #(
            .SW  (SW),
            .LEN (branch_len(MODE_E, b, P, D))
         ) u_buf (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[b]),
            .wr_data (in_data),
            .rd_data (rd_data[b]),
            .full    (full[b])
         );
      end
   endgenerate

   // A branch counts as primed once it has emitted real (non-fill) data, so
   // out_primed rises together with the first non-fill symbol of the last branch.
   assign emitted_next = emitted | (wr_en & full);

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_branch <= '0;
         out_primed <= 1'b0;
         emitted    <= '0;
      end else if (accept) begin
         idx        <= idx_next;
         out_valid  <= 1'b1;
         out_data   <= rd_data[branch_sel];
         out_branch <= branch_sel;
         emitted    <= emitted_next;
         out_primed <= out_primed | (&emitted_next);
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ci_symbol_interleaver.sv
// Directed bench: interleave pattern, interleave->deinterleave round trip under
// backpressure, sync override, mid-stream reset, P=1 and MODE=1/P=2/D=1 instances.
module tb_ci_symbol_interleaver;

   localparam int SW = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Interleaver (P=4, D=2) feeding a deinterleaver with the same geometry
   logic [SW-1:0] il_in_data;
   logic          il_in_valid, il_in_ready, il_in_sync;
   logic [SW-1:0] il_out_data;
   logic          il_out_valid, il_out_primed;
   logic [1:0]    il_out_branch;

   logic          dl_in_ready, dl_in_sync;
   logic [SW-1:0] dl_out_data;
   logic          dl_out_valid, dl_out_ready, dl_out_primed;
   logic [1:0]    dl_out_branch;

   logic [SW-1:0] p1_in_data, p1_out_data;
   logic          p1_in_valid, p1_in_ready, p1_in_sync;
   logic          p1_out_valid, p1_out_ready, p1_out_primed;
   logic [0:0]    p1_out_branch;

   logic [SW-1:0] m1_in_data, m1_out_data;
   logic          m1_in_valid, m1_in_ready, m1_in_sync;
   logic          m1_out_valid, m1_out_ready, m1_out_primed;
   logic [0:0]    m1_out_branch;

   ci_symbol_interleaver #(.M(10), .W(1), .D(2), .P(4), .MODE(0)) u_il (
      .clk(clk), .rst(rst),
      .in_data(il_in_data), .in_valid(il_in_valid), .in_ready(il_in_ready), .in_sync(il_in_sync),
      .out_data(il_out_data), .out_valid(il_out_valid), .out_ready(dl_in_ready),
      .out_branch(il_out_branch), .out_primed(il_out_primed)
   );

   ci_symbol_interleaver #(.M(10), .W(1), .D(2), .P(4), .MODE(1)) u_dl (
      .clk(clk), .rst(rst),
      .in_data(il_out_data), .in_valid(il_out_valid), .in_ready(dl_in_ready), .in_sync(dl_in_sync),
      .out_data(dl_out_data), .out_valid(dl_out_valid), .out_ready(dl_out_ready),
      .out_branch(dl_out_branch), .out_primed(dl_out_primed)
   );

   ci_symbol_interleaver #(.M(10), .W(1), .D(2), .P(1), .MODE(0)) u_p1 (
      .clk(clk), .rst(rst),
      .in_data(p1_in_data), .in_valid(p1_in_valid), .in_ready(p1_in_ready), .in_sync(p1_in_sync),
      .out_data(p1_out_data), .out_valid(p1_out_valid), .out_ready(p1_out_ready),
      .out_branch(p1_out_branch), .out_primed(p1_out_primed)
   );

   ci_symbol_interleaver #(.M(10), .W(1), .D(1), .P(2), .MODE(1)) u_m1 (
      .clk(clk), .rst(rst),
      .in_data(m1_in_data), .in_valid(m1_in_valid), .in_ready(m1_in_ready), .in_sync(m1_in_sync),
      .out_data(m1_out_data), .out_valid(m1_out_valid), .out_ready(m1_out_ready),
      .out_branch(m1_out_branch), .out_primed(m1_out_primed)
   );

   task automatic do_reset();
      rst          = 1'b1;
      il_in_valid  = 1'b0;
      il_in_sync   = 1'b0;
      il_in_data   = '0;
      dl_in_sync   = 1'b0;
      dl_out_ready = 1'b1;
      p1_in_valid  = 1'b0;
      p1_in_sync   = 1'b0;
      p1_in_data   = '0;
      p1_out_ready = 1'b1;
      m1_in_valid  = 1'b0;
      m1_in_sync   = 1'b0;
      m1_in_data   = '0;
      m1_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic int il_pattern(int j);
      int e;
      e = j - 8 * (3 - (j % 4));
      return (e < 0) ? 0 : e;
   endfunction

   task automatic test_reset();
      do_reset();
      checks++; if (il_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", il_in_ready); end
      checks++; if (il_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", il_out_valid); end
      checks++; if (il_out_data !== '0) begin failures++; $display("[TB] FAIL reset_out_data got=%0d exp=0", il_out_data); end
      checks++; if (il_out_branch !== 2'd0) begin failures++; $display("[TB] FAIL reset_out_branch got=%0d exp=0", il_out_branch); end
      checks++; if (il_out_primed !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_primed got=%b exp=0", il_out_primed); end
      checks++; if (dl_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_dl_valid got=%b exp=0", dl_out_valid); end
      checks++; if (p1_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_p1_valid got=%b exp=0", p1_out_valid); end
      checks++; if (m1_out_primed !== 1'b0) begin failures++; $display("[TB] FAIL reset_m1_primed got=%b exp=0", m1_out_primed); end
   endtask

   task automatic test_interleave();
      do_reset();
      for (int k = 0; k < 64; k++) begin
         il_in_valid = 1'b1;
         il_in_data  = 10'(k);
         @(posedge clk); #1;
         checks++; if (il_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL il_valid j=%0d got=%b exp=1", k, il_out_valid); end
         checks++; if (il_out_data !== 10'(il_pattern(k))) begin failures++; $display("[TB] FAIL il_data j=%0d got=%0d exp=%0d", k, il_out_data, il_pattern(k)); end
         checks++; if (il_out_primed !== (k >= 24)) begin failures++; $display("[TB] FAIL il_primed j=%0d got=%b exp=%b", k, il_out_primed, k >= 24); end
         checks++; if (il_out_branch !== 2'(k % 4)) begin failures++; $display("[TB] FAIL il_branch j=%0d got=%0d exp=%0d", k, il_out_branch, k % 4); end
      end
      il_in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [SW-1:0] sent [200];
      logic [SW-1:0] held_data;
      bit            held;
      bit            done;
      int            j;
      int            exp_v;
      do_reset();
      for (int k = 0; k < 200; k++) sent[k] = 10'($urandom_range(1, 1023));
      held = 1'b0;
      done = 1'b0;
      j    = 0;
      fork
         begin
            for (int k = 0; k < 200; k++) begin
               bit acc;
               repeat ($urandom_range(0, 2)) begin
                  il_in_valid = 1'b0;
                  @(posedge clk); #1;
               end
               il_in_valid = 1'b1;
               il_in_data  = sent[k];
               acc = 1'b0;
               for (int c = 0; c < 50 && !acc; c++) begin
                  @(negedge clk);
                  acc = il_in_ready;
                  @(posedge clk); #1;
               end
               if (!acc) break;
            end
            il_in_valid = 1'b0;
         end
         begin
            while (!done) begin
               dl_out_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            dl_out_ready = 1'b1;
         end
         begin
            for (int c = 0; c < 4000 && j < 200; c++) begin
               @(negedge clk);
               if (held) begin
                  checks++;
                  if (dl_out_valid !== 1'b1 || dl_out_data !== held_data) begin
                     failures++;
                     $display("[TB] FAIL rt_stall_hold got=%0d/%b exp=%0d/1", dl_out_data, dl_out_valid, held_data);
                  end
               end
               held = 1'b0;
               if (dl_out_valid && dl_out_ready) begin
                  exp_v = (j >= 24) ? int'(sent[j-24]) : 0;
                  checks++;
                  if (dl_out_data !== 10'(exp_v)) begin
                     failures++;
                     $display("[TB] FAIL rt_data j=%0d got=%0d exp=%0d", j, dl_out_data, exp_v);
                  end
                  j++;
               end else if (dl_out_valid) begin
                  held      = 1'b1;
                  held_data = dl_out_data;
               end
            end
            done = 1'b1;
            checks++;
            if (j != 200) begin failures++; $display("[TB] FAIL rt_count got=%0d exp=200", j); end
         end
      join
      @(posedge clk); #1;
   endtask

   task automatic test_sync();
      int exp_br [14] = '{0, 1, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
      int exp_d  [14] = '{0, 0, 0, 0, 0, 105, 0, 0, 0, 109, 0, 0, 104, 113};
      do_reset();
      for (int k = 0; k < 14; k++) begin
         il_in_valid = 1'b1;
         il_in_data  = 10'(100 + k);
         il_in_sync  = (k == 2);
         @(posedge clk); #1;
         checks++; if (il_out_branch !== 2'(exp_br[k])) begin failures++; $display("[TB] FAIL sync_branch k=%0d got=%0d exp=%0d", k, il_out_branch, exp_br[k]); end
         checks++; if (il_out_data !== 10'(exp_d[k])) begin failures++; $display("[TB] FAIL sync_data k=%0d got=%0d exp=%0d", k, il_out_data, exp_d[k]); end
      end
      il_in_valid = 1'b0;
      il_in_sync  = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 40; k++) begin
         il_in_valid = 1'b1;
         il_in_data  = 10'(k);
         @(posedge clk); #1;
      end
      il_in_data = 10'(40);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      il_in_valid = 1'b0;
      checks++; if (il_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmid_valid got=%b exp=0", il_out_valid); end
      checks++; if (il_out_primed !== 1'b0) begin failures++; $display("[TB] FAIL rmid_primed got=%b exp=0", il_out_primed); end
      checks++; if (il_out_data !== '0) begin failures++; $display("[TB] FAIL rmid_data got=%0d exp=0", il_out_data); end
      checks++; if (il_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmid_ready got=%b exp=1", il_in_ready); end
      for (int k = 0; k < 32; k++) begin
         il_in_valid = 1'b1;
         il_in_data  = 10'(k);
         @(posedge clk); #1;
         checks++; if (il_out_data !== 10'(il_pattern(k))) begin failures++; $display("[TB] FAIL rmid_refill j=%0d got=%0d exp=%0d", k, il_out_data, il_pattern(k)); end
         checks++; if (il_out_primed !== (k >= 24)) begin failures++; $display("[TB] FAIL rmid_reprimed j=%0d got=%b exp=%b", k, il_out_primed, k >= 24); end
      end
      il_in_valid = 1'b0;
   endtask

   task automatic test_pass_p1();
      do_reset();
      p1_in_valid = 1'b1;
      p1_in_data  = 10'h155;
      @(posedge clk); #1;
      checks++; if (p1_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL p1_valid got=%b exp=1", p1_out_valid); end
      checks++; if (p1_out_data !== 10'h155) begin failures++; $display("[TB] FAIL p1_data got=%h exp=155", p1_out_data); end
      checks++; if (p1_out_branch !== 1'b0) begin failures++; $display("[TB] FAIL p1_branch got=%0d exp=0", p1_out_branch); end
      p1_in_data   = 10'h2AA;
      p1_out_ready = 1'b0;
      #1;
      checks++; if (p1_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL p1_stall_ready got=%b exp=0", p1_in_ready); end
      @(posedge clk); #1;
      checks++; if (p1_out_data !== 10'h155 || p1_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL p1_hold got=%h/%b exp=155/1", p1_out_data, p1_out_valid); end
      p1_out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (p1_out_data !== 10'h2AA) begin failures++; $display("[TB] FAIL p1_resume got=%h exp=2aa", p1_out_data); end
      p1_in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (p1_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL p1_drain got=%b exp=0", p1_out_valid); end
   endtask

   task automatic test_mode1_p2();
      int exp_d [8] = '{1, 0, 3, 2, 5, 4, 7, 6};
      do_reset();
      for (int k = 0; k < 8; k++) begin
         m1_in_valid = 1'b1;
         m1_in_data  = 10'(k + 1);
         @(posedge clk); #1;
         checks++; if (m1_out_data !== 10'(exp_d[k])) begin failures++; $display("[TB] FAIL m1_data j=%0d got=%0d exp=%0d", k, m1_out_data, exp_d[k]); end
         checks++; if (m1_out_branch !== 1'(k % 2)) begin failures++; $display("[TB] FAIL m1_branch j=%0d got=%0d exp=%0d", k, m1_out_branch, k % 2); end
      end
      m1_in_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_interleave();
      test_back_to_back();
      test_sync();
      test_reset_mid();
      test_pass_p1();
      test_mode1_p2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ci_symbol_interleaver.md
# ci_symbol_interleaver

Symbol-wide, parametrised convolutional interleaver/deinterleaver with valid/ready flow control on both sides. It accepts one CI symbol (W outer-FEC symbols of M bits) per handshake and distributes symbols round-robin over P branches, with branch delays set by MODE. Each branch is a circular buffer, not a shift register. It sits between the outer-FEC symbol framing and the inner-FEC/PCS serialiser, and replaces bit-serial interleaving with a pipelined symbol path that supports backpressure and codeword alignment.

## Interface
- M, 10, bits per outer-FEC symbol
- W, 1, outer-FEC symbols per CI symbol; symbol width SW = M*W
- D, 2, delay constant in branch-symbols (≥1)
- P, 4, number of branches (≥1)
- MODE, 0, 0 = interleave (branch i delay (P-1-i)*D), 1 = deinterleave (branch i delay i*D)

Ports:
- clk  in  1  clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous active-high reset
- in_data  in  SW  input CI symbol
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept
- in_sync  in  1  qualified by in_valid; this symbol is forced to branch 0
- out_data  out  SW  output CI symbol
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream can accept
- out_branch  out  max(1,$clog2(P))  branch that produced out_data
- out_primed  out  1  all branches have been filled since reset; output is no longer fill

## Operation
- Accept = in_valid && in_ready. Emit = out_valid && out_ready.
- Commutator index idx is in 0..P-1. Branch b = in_sync ? 0 : idx. After an accept, idx becomes (b+1) mod P.
- Branch b has length L_b per MODE. If L_b = 0, the output is in_data directly.
- Otherwise the branch has memory mem_b[L_b] and pointer ptr_b:
  - on accept: output = mem_b[ptr_b]; mem_b[ptr_b] ← in_data; ptr_b ← (ptr_b+1) mod L_b.
- Fill tracking:
  - cnt_b saturates at L_b; it increments on each accept to b.
  - While cnt_b < L_b, the output symbol is forced to all-zero (memories are never reset).
- out_primed = 1 once every cnt_b = L_b. It stays 1 until rst.
- In-order property: interleave followed by deinterleave with equal P and D returns the input delayed by exactly P*(P-1)*D symbols.
- P = 1: pure register stage; out_branch is held at 0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_branch=0, out_primed=0, idx=0, all ptr_b=0, all cnt_b=0.
- Latency is 1 cycle: the symbol accepted at edge n is presented with out_valid=1 after edge n.
- Single output register: in_ready = !out_valid || out_ready, a combinational pass-through of out_ready.
  - Accept and emit at the same edge give full throughput (1 symbol/cycle).
  - If out_ready=0 while out_valid=1, then in_ready=0 and out_data/out_branch are held stable.
  - No branch state changes without an accept.
- in_sync with in_idx already 0 has no effect. Mid-rotation in_sync skips the remaining branches; the skipped branches' pointers and counters do not move.
- rst asserted mid-stream takes priority over any handshake at that edge. Everything returns to reset values and fill restarts (zero output until refilled). Stale memory contents are never emitted.
- Pointer wrap: ptr_b = L_b-1 wraps to 0 on the next accept to b.

## Structure
- Package ci_pkg:
  - ci_mode_e {CI_INTERLEAVE, CI_DEINTERLEAVE}
  - function branch_len(mode, i, P, D)
  - function clog2_min1
- Sub-module ci_branch_buf, parametrised (SW, LEN). It owns mem, ptr and cnt, and outputs rd_data (zero-forced while filling) and full. LEN = 0 is handled by a generate bypass.
- Top level holds idx, the in_sync override, the branch select/mux, the output register, the handshake and out_primed.

## Test plan
- Interleave P=4, D=2, M=10, W=1, symbols k=0..63 with value k, out_ready=1. Required: out_data at position j = j-8*(3-(j mod 4)) when ≥0, else 0. Positions 3 and 7 carry 3 and 7; position 10 carries 2. out_primed rises with output position 24.
- Round trip: interleave instance feeding a deinterleave instance (P=4, D=2), 200 random symbols. Required: output j = input j-24 for j≥24, and 0 before.
- Backpressure: random out_ready (50%) plus random in_valid gaps. Required: output sequence identical to the stall-free run, no drops or duplicates, and out_data stable while stalled.
- Sync: in_sync on symbol 2 of a rotation (P=4). Required: out_branch sequence 0,1,0,1,2,3, and branches 2/3 counters unchanged by the skip.
- Reset mid-stream: rst for 1 cycle after 40 symbols. Required: next cycle out_valid=0 and out_primed=0; the following outputs restart the zero-fill pattern of the first test.
- Degenerate: P=1 gives 1-cycle pass-through. MODE=1, P=2, D=1: branch 1 delays by exactly 1 branch-symbol (2 input symbols).
